// File: rtl/wishbone_arbiter_pkg.sv
// Shared bus widths, FSM state type and default ACK timeout for the arbiter.
package wishbone_arbiter_pkg;

  localparam int unsigned WB_ADR_W        = 16;
  localparam int unsigned WB_DAT_W        = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned TMO_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CYCLE = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wishbone_arbiter_timeout_counter.sv
// ACK timeout counter: cleared outside CYCLE, counts CYCLE cycles without ACK,
// hit when the count reaches TIMEOUT-1. TIMEOUT=0 forces hit low.
module wb_timeout_counter
  import wishbone_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic                 TMO_ON = (TIMEOUT != 0);
  localparam logic [TMO_CNT_W-1:0] LAST   = TMO_CNT_W'(TIMEOUT - 1);

  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = TMO_ON && (cnt_q == LAST);

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-requester round-robin Wishbone classic single-cycle bus controller.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_rd,
  input  logic                m0_wr,
  input  logic [WB_ADR_W-1:0] m0_adr,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  output logic                m0_done,
  output logic                m0_err,
  input  logic                m1_rd,
  input  logic                m1_wr,
  input  logic [WB_ADR_W-1:0] m1_adr,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  output logic                m1_done,
  output logic                m1_err,
  input  logic                ack_i,
  input  logic [WB_DAT_W-1:0] dat_i,
  output logic [WB_DAT_W-1:0] dat_o,
  output logic [WB_ADR_W-1:0] adr_o,
  output logic                we_o,
  output logic                stb_o,
  output logic                cyc_o,
  output logic [1:0]          gnt_o
);

  wb_state_e           state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] wdat_q, wdat_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                last_q, last_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic [WB_DAT_W-1:0] rdat0_q, rdat0_d;
  logic [WB_DAT_W-1:0] rdat1_q, rdat1_d;
  logic [1:0]          req;
  logic                pick;
  logic                tmo_hit;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != ST_CYCLE),
    .en_i  ((state_q == ST_CYCLE) && !ack_i),
    .hit_o (tmo_hit)
  );

  // Round-robin pick: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    req = {m1_rd | m1_wr, m0_rd | m0_wr};
    if (&req) begin
      pick = ~last_q;
    end else begin
      pick = req[1];
    end
  end

  // Next-state and registered-output logic; CYCLE owner is gnt_q[1].
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    done_d  = '0;
    err_d   = '0;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_CYCLE;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          gnt_d   = owner_onehot(pick);
          last_d  = pick;
          if (pick) begin
            adr_d  = m1_adr;
            wdat_d = m1_dat_i;
            we_d   = m1_wr;
          end else begin
            adr_d  = m0_adr;
            wdat_d = m0_dat_i;
            we_d   = m0_wr;
          end
        end
      end
      ST_CYCLE: begin
        if (ack_i || tmo_hit) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          gnt_d   = '0;
          if (ack_i) begin
            done_d[gnt_q[1]] = 1'b1;
            if (!we_q) begin
              if (gnt_q[1]) begin
                rdat1_d = dat_i;
              end else begin
                rdat0_d = dat_i;
              end
            end
          end else begin
            err_d[gnt_q[1]] = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset drops the bus immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      done_q  <= '0;
      err_q   <= '0;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
    end
  end

  assign cyc_o    = cyc_q;
  assign stb_o    = stb_q;
  assign we_o     = we_q;
  assign adr_o    = adr_q;
  assign dat_o    = wdat_q;
  assign gnt_o    = gnt_q;
  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_dat_o = rdat0_q;
  assign m1_dat_o = rdat1_q;

endmodule
